// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / pipeline-control unit.
//   - hazard_state_e : control FSM states (boot flush, normal run, memory wait)
//   - FWD_*          : ForwardAE/ForwardBE select encodings
//   - fwd_sel()      : forwarding priority rule (M stage wins over W stage)
package hazard_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2
    } hazard_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count
//   en_i   : count this cycle
//   cnt_o  : current count, holds at all-ones
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and pipeline-control unit for the five-stage RISC-V core.
// Forwarding and load-use detection plus a small FSM that flushes the pipeline
// after reset, freezes it while the data memory is busy and flags runaway waits.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE     register indices in Decode / Execute
//   RdM/RdW, RegWriteM/RegWriteW destination + write enable in Memory / Writeback
//   ResultSrcE                   bit 0 marks a load in Execute
//   PCSrcE                       taken branch/jump resolved in Execute
//   MemReqM, MemReadyM           data memory request / completion
//   Stall*, FlushD, FlushE       pipeline register controls (combinational)
//   ForwardAE/BE                 operand forward selects (combinational)
//   mem_timeout                  sticky flag: wait count reached WAIT_MAX
//   stall_cnt, flush_cnt         perf counters
//
// Build option: define HAZARD_PERF_CNT_EN to implement the perf counters;
// otherwise both counter ports are tied to zero.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned WAIT_MAX    = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned BootW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
    localparam int unsigned WaitW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    hazard_state_e    state_d, state_q;
    logic [BootW-1:0] boot_cnt_d, boot_cnt_q;
    logic [WaitW-1:0] wait_cnt_d, wait_cnt_q;
    logic             timeout_d, timeout_q;

    logic lw;
    logic frz;
    logic boot_done;

    // Only bit 0 of ResultSrcE identifies a load.
    logic unused_result_src;
    assign unused_result_src = ResultSrcE[1];

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign lw  = ResultSrcE[0] && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign frz = MemReqM && !MemReadyM;

    assign boot_done = (32'(boot_cnt_q) + 32'd1) >= BOOT_CYCLES;

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        StallW     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;

        unique case (state_q)
            StBoot: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (boot_done) begin
                    state_d    = StRun;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + BootW'(1);
                end
            end
            StRun, StWait: begin
                if (frz) begin
                    // Freeze everything, W included: rewriting the same value is
                    // harmless and keeps the W forwarding path valid. A pending
                    // PCSrcE stays held in E and redirects on release.
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    StallM  = 1'b1;
                    StallW  = 1'b1;
                    state_d = StWait;
                    if (state_q == StRun) begin
                        wait_cnt_d = WaitW'(1);
                    end else if (wait_cnt_q != {WaitW{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
                    if (wait_cnt_d == WaitW'(WAIT_MAX)) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    StallF     = lw;
                    StallD     = lw;
                    FlushD     = PCSrcE;
                    FlushE     = lw | PCSrcE;
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_cnt_en;
    logic flush_cnt_en;

    assign stall_cnt_en = ((state_q == StRun) || (state_q == StWait)) && StallF;
    assign flush_cnt_en = (state_q == StRun) && PCSrcE && !frz;

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (stall_cnt_en),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (flush_cnt_en),
        .cnt_o  (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (BOOT_CYCLES=2, WAIT_MAX=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_unit;

    localparam int unsigned CNT_W = 32;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [4:0] stalls;
    logic [1:0] flushes;
    assign stalls  = {StallF, StallD, StallE, StallM, StallW};
    assign flushes = {FlushD, FlushE};

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit #(
        .BOOT_CYCLES (2),
        .WAIT_MAX    (4),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .ResultSrcE  (ResultSrcE),
        .PCSrcE      (PCSrcE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    // Boot window: flush for two cycles after release, then quiet RUN.
    task automatic check_boot(input string tag);
        #1;
        check_eq({tag, "_boot1_flush"}, 32'(flushes), 32'h3);
        check_eq({tag, "_boot1_stall"}, 32'(stalls), 32'h0);
        next_cycle(); #1;
        check_eq({tag, "_boot2_flush"}, 32'(flushes), 32'h3);
        next_cycle(); #1;
        check_eq({tag, "_run_flush"}, 32'(flushes), 32'h0);
        check_eq({tag, "_run_stall"}, 32'(stalls), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Forwarding is live even in reset.
        RdW = 5'd3; RegWriteW = 1'b1; Rs2E = 5'd3;
        next_cycle(); next_cycle(); #1;
        check_eq("rst_flush", 32'(flushes), 32'h3);
        check_eq("rst_stall", 32'(stalls), 32'h0);
        check_eq("rst_timeout", 32'(mem_timeout), 32'h0);
        check_eq("rst_stall_cnt", stall_cnt, 32'h0);
        check_eq("rst_flush_cnt", flush_cnt, 32'h0);
        check_eq("rst_fwdB", 32'(ForwardBE), 32'h1);

        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        check_boot("post_rst");

        // Forwarding priority and x0 suppression.
        next_cycle();
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd6;
        #1;
        check_eq("fwdA_m", 32'(ForwardAE), 32'h2);
        check_eq("fwdB_none", 32'(ForwardBE), 32'h0);
        RegWriteM = 1'b0;
        #1;
        check_eq("fwdA_w", 32'(ForwardAE), 32'h1);
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1; Rs1E = 5'd0;
        #1;
        check_eq("fwdA_x0", 32'(ForwardAE), 32'h0);
        RdM = 5'd6; RdW = 5'd6; RegWriteW = 1'b1;
        #1;
        check_eq("fwdB_m", 32'(ForwardBE), 32'h2);
        check_eq("fwd_stall", 32'(stalls), 32'h0);

        // Load-use hazard.
        next_cycle();
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        check_eq("lw_stall", 32'(stalls), 32'h18);
        check_eq("lw_flush", 32'(flushes), 32'h1);
        check_eq("lw_cnt_before", stall_cnt, 32'h0);
        next_cycle();
        RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
        #1;
        check_eq("lw_rd0_stall", 32'(stalls), 32'h0);
        check_eq("lw_stall_cnt", stall_cnt, PerfEn ? 32'd1 : 32'd0);

        // Taken branch.
        next_cycle();
        clear_inputs();
        PCSrcE = 1'b1;
        #1;
        check_eq("br_flush", 32'(flushes), 32'h3);
        check_eq("br_stall", 32'(stalls), 32'h0);
        next_cycle();
        PCSrcE = 1'b0;
        #1;
        check_eq("br_flush_cnt", flush_cnt, PerfEn ? 32'd1 : 32'd0);

        // Three-cycle freeze with a pending redirect.
        next_cycle();
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("frz%0d_stall", i), 32'(stalls), 32'h1f);
            check_eq($sformatf("frz%0d_flush", i), 32'(flushes), 32'h0);
            next_cycle();
        end
        MemReadyM = 1'b1;
        #1;
        check_eq("frz_rel_flush", 32'(flushes), 32'h3);
        check_eq("frz_rel_stall", 32'(stalls), 32'h0);
        next_cycle();
        clear_inputs();
        #1;
        check_eq("frz_after_flush", 32'(flushes), 32'h0);
        check_eq("frz_timeout", 32'(mem_timeout), 32'h0);
        check_eq("frz_stall_cnt", stall_cnt, PerfEn ? 32'd4 : 32'd0);
        check_eq("frz_flush_cnt", flush_cnt, PerfEn ? 32'd1 : 32'd0);

        // Runaway wait: timeout rises after the 4th wait cycle; lw is overridden.
        next_cycle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9;
        for (int i = 1; i <= 6; i++) begin
            #1;
            check_eq($sformatf("to%0d_flag", i), 32'(mem_timeout), (i >= 5) ? 32'h1 : 32'h0);
            check_eq($sformatf("to%0d_stall", i), 32'(stalls), 32'h1f);
            check_eq($sformatf("to%0d_flush", i), 32'(flushes), 32'h0);
            next_cycle();
        end
        clear_inputs();
        MemReqM = 1'b1; MemReadyM = 1'b1;
        #1;
        check_eq("to_rel_stall", 32'(stalls), 32'h0);
        next_cycle();
        clear_inputs();
        #1;
        check_eq("to_sticky", 32'(mem_timeout), 32'h1);

        // Reset asserted in the middle of a freeze.
        next_cycle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        next_cycle();
        #1;
        check_eq("mid_frz_stall", 32'(stalls), 32'h1f);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_flush", 32'(flushes), 32'h3);
        check_eq("mid_rst_stall", 32'(stalls), 32'h0);
        check_eq("mid_rst_timeout", 32'(mem_timeout), 32'h0);
        check_eq("mid_rst_stall_cnt", stall_cnt, 32'h0);
        check_eq("mid_rst_flush_cnt", flush_cnt, 32'h0);
        next_cycle();
        clear_inputs();
        next_cycle();
        rst_n = 1'b1;
        check_boot("re_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
